// File: rtl/bsg_manycore_pkg.sv
// Shared manycore definitions: pod reset command encoding, sequencer
// state encoding and a safe clog2 helper for parameter-derived widths.
package bsg_manycore_pkg;

   typedef enum logic [1:0] {
      e_pod_reset_assert_all  = 2'd0,
      e_pod_reset_release_all = 2'd1,
      e_pod_reset_pulse_one   = 2'd2,
      e_pod_reset_nop         = 2'd3
   } bsg_manycore_pod_reset_cmd_e;

   typedef enum logic [1:0] {
      e_prs_idle    = 2'd0,
      e_prs_hold    = 2'd1,
      e_prs_stagger = 2'd2,
      e_prs_done    = 2'd3
   } bsg_manycore_pod_reset_state_e;

   // clog2 that never returns 0, so a 1-entry range still gets a 1-bit field
   function automatic int safe_clog2(input int val);
      return (val <= 1) ? 1 : $clog2(val);
   endfunction

endpackage

// File: rtl/bsg_manycore_pod_reset_sequencer.sv
// Pod reset sequencer: accepts one command at a time and drives the
// registered per-pod reset vector (global assert, staggered release in
// ascending linear index order, single-pod recovery pulse).
module bsg_manycore_pod_reset_sequencer
   import bsg_manycore_pkg::*;
#(
   parameter int num_pods_x_p        = 1,
   parameter int num_pods_y_p        = 1,
   parameter int hold_cycles_p       = 16,
   parameter int stagger_cycles_p    = 8,
   parameter int pod_x_cord_width_lp = safe_clog2(num_pods_x_p),
   parameter int pod_y_cord_width_lp = safe_clog2(num_pods_y_p)
) (
   input  logic                                          clk_i,
   input  logic                                          reset_n_i,
   input  logic                                          v_i,
   output logic                                          ready_o,
   input  bsg_manycore_pod_reset_cmd_e                   cmd_i,
   input  logic [pod_x_cord_width_lp-1:0]                pod_x_i,
   input  logic [pod_y_cord_width_lp-1:0]                pod_y_i,
   output logic [num_pods_y_p-1:0][num_pods_x_p-1:0]     pod_reset_o,
   output logic                                          busy_o,
   output logic                                          done_o
);

   localparam int num_pods_lp    = num_pods_x_p * num_pods_y_p;
   localparam int max_cycles_lp  = (hold_cycles_p > stagger_cycles_p) ? hold_cycles_p : stagger_cycles_p;
   localparam int timer_width_lp = safe_clog2(max_cycles_lp);
   localparam int idx_width_lp   = safe_clog2(num_pods_lp);

   localparam logic [timer_width_lp-1:0] hold_load_lp    = timer_width_lp'(hold_cycles_p - 1);
   localparam logic [timer_width_lp-1:0] stagger_load_lp = timer_width_lp'(stagger_cycles_p - 1);
   localparam logic [idx_width_lp-1:0]   last_idx_lp     = idx_width_lp'(num_pods_lp - 1);

   bsg_manycore_pod_reset_state_e state_q, state_d;
   logic [timer_width_lp-1:0]     timer_q, timer_d;
   logic [idx_width_lp-1:0]       idx_q, idx_d;
   logic [num_pods_lp-1:0]        pod_reset_q, pod_reset_d;
   logic                          pulse_q, pulse_d;   // HOLD belongs to PULSE_ONE (clear bit on exit)
   logic                          last_q, last_d;     // final pod already released, leave STAGGER next
   logic                          ready_q, ready_d;
   logic                          busy_q, busy_d;
   logic                          done_q, done_d;

   logic                          in_range_s;
   logic [idx_width_lp-1:0]       target_idx_s;

   // Decode the PULSE_ONE target into a linear index and range-check it
   always_comb begin
      in_range_s   = (32'(pod_x_i) < num_pods_x_p) && (32'(pod_y_i) < num_pods_y_p);
      target_idx_s = idx_width_lp'(pod_y_i) * idx_width_lp'(num_pods_x_p) + idx_width_lp'(pod_x_i);
   end

   // Next-state logic for the command FSM, timer, index counter and reset vector
   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      idx_d       = idx_q;
      pod_reset_d = pod_reset_q;
      pulse_d     = pulse_q;
      last_d      = last_q;

      case (state_q)
         e_prs_idle: begin
            if (v_i) begin
               case (cmd_i)
                  e_pod_reset_assert_all: begin
                     pod_reset_d = {num_pods_lp{1'b1}};
                     timer_d     = hold_load_lp;
                     pulse_d     = 1'b0;
                     state_d     = e_prs_hold;
                  end
                  e_pod_reset_release_all: begin
                     pod_reset_d[0] = 1'b0;
                     if (num_pods_lp == 1) begin
                        state_d = e_prs_done;
                     end else begin
                        idx_d   = idx_width_lp'(1);
                        timer_d = stagger_load_lp;
                        last_d  = 1'b0;
                        state_d = e_prs_stagger;
                     end
                  end
                  e_pod_reset_pulse_one: begin
                     if (in_range_s) begin
                        pod_reset_d[target_idx_s] = 1'b1;
                        idx_d   = target_idx_s;
                        timer_d = hold_load_lp;
                        pulse_d = 1'b1;
                        state_d = e_prs_hold;
                     end else begin
                        state_d = e_prs_done;
                     end
                  end
                  default: begin
                     state_d = e_prs_done;
                  end
               endcase
            end else begin
               state_d = e_prs_idle;
            end
         end

         e_prs_hold: begin
            if (timer_q == timer_width_lp'(0)) begin
               state_d = e_prs_done;
               if (pulse_q) begin
                  pod_reset_d[idx_q] = 1'b0;
               end else begin
                  pod_reset_d = pod_reset_q;
               end
            end else begin
               timer_d = timer_q - timer_width_lp'(1);
            end
         end

         e_prs_stagger: begin
            if (last_q) begin
               state_d = e_prs_done;
            end else if (timer_q == timer_width_lp'(0)) begin
               pod_reset_d[idx_q] = 1'b0;
               timer_d            = stagger_load_lp;
               if (idx_q == last_idx_lp) begin
                  last_d = 1'b1;
               end else begin
                  idx_d = idx_q + idx_width_lp'(1);
               end
            end else begin
               timer_d = timer_q - timer_width_lp'(1);
            end
         end

         e_prs_done: begin
            state_d = e_prs_idle;
         end

         default: begin
            state_d = e_prs_idle;
         end
      endcase

      ready_d = (state_d == e_prs_idle);
      busy_d  = (state_d == e_prs_hold) || (state_d == e_prs_stagger);
      done_d  = (state_d == e_prs_done);
   end

   // State, counters, reset vector and status flags; reset forces every pod into reset
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q     <= e_prs_idle;
         timer_q     <= '0;
         idx_q       <= '0;
         pod_reset_q <= {num_pods_lp{1'b1}};
         pulse_q     <= 1'b0;
         last_q      <= 1'b0;
         ready_q     <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         idx_q       <= idx_d;
         pod_reset_q <= pod_reset_d;
         pulse_q     <= pulse_d;
         last_q      <= last_d;
         ready_q     <= ready_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign pod_reset_o = pod_reset_q;
   assign ready_o     = ready_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;

endmodule

// File: tb/tb_bsg_manycore_pod_reset_sequencer.sv
// Directed bench for the pod reset sequencer: 2x2 pods, hold 4, stagger 3,
// plus a 2x3 instance whose row field can encode an out-of-range target.
module tb_bsg_manycore_pod_reset_sequencer;
   import bsg_manycore_pkg::*;

   logic clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   logic                        reset_n_i;
   logic                        v_i, ready_o, busy_o, done_o;
   bsg_manycore_pod_reset_cmd_e cmd_i;
   logic [0:0]                  pod_x_i, pod_y_i;
   logic [1:0][1:0]             pod_reset_o;

   logic                        v2_i, ready2_o, busy2_o, done2_o;
   bsg_manycore_pod_reset_cmd_e cmd2_i;
   logic [0:0]                  pod_x2_i;
   logic [1:0]                  pod_y2_i;
   logic [2:0][1:0]             pod_reset2_o;

   int checks = 0;
   int errors = 0;

   bsg_manycore_pod_reset_sequencer #(
      .num_pods_x_p(2), .num_pods_y_p(2), .hold_cycles_p(4), .stagger_cycles_p(3)
   ) dut (
      .clk_i(clk_i), .reset_n_i(reset_n_i), .v_i(v_i), .ready_o(ready_o),
      .cmd_i(cmd_i), .pod_x_i(pod_x_i), .pod_y_i(pod_y_i),
      .pod_reset_o(pod_reset_o), .busy_o(busy_o), .done_o(done_o)
   );

   bsg_manycore_pod_reset_sequencer #(
      .num_pods_x_p(2), .num_pods_y_p(3), .hold_cycles_p(4), .stagger_cycles_p(3)
   ) dut2 (
      .clk_i(clk_i), .reset_n_i(reset_n_i), .v_i(v2_i), .ready_o(ready2_o),
      .cmd_i(cmd2_i), .pod_x_i(pod_x2_i), .pod_y_i(pod_y2_i),
      .pod_reset_o(pod_reset2_o), .busy_o(busy2_o), .done_o(done2_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      reset_n_i = 1'b0;
      v_i = 1'b0; cmd_i = e_pod_reset_nop; pod_x_i = 1'b0; pod_y_i = 1'b0;
      v2_i = 1'b0; cmd2_i = e_pod_reset_nop; pod_x2_i = 1'b0; pod_y2_i = 2'd0;
      tick(); tick();
      chk("rst_active_pod", 32'(pod_reset_o), 32'h0000_000F);
      @(negedge clk_i) reset_n_i = 1'b1;
      tick();
      chk("rst_pod",   32'(pod_reset_o), 32'h0000_000F);
      chk("rst_ready", 32'(ready_o), 32'd1);
      chk("rst_busy",  32'(busy_o),  32'd0);
      chk("rst_done",  32'(done_o),  32'd0);
      chk("rst_pod2",  32'(pod_reset2_o), 32'h0000_003F);

      // RELEASE_ALL: pods drop at T+1/4/7/10, done at T+11, ready at T+12
      v_i = 1'b1; cmd_i = e_pod_reset_release_all;
      tick();
      v_i = 1'b0; cmd_i = e_pod_reset_nop;
      for (int k = 1; k <= 12; k++) begin
         chk($sformatf("rel_pod_k%0d", k), 32'(pod_reset_o),
             (k >= 10) ? 32'h0 : (k >= 7) ? 32'h8 : (k >= 4) ? 32'hC : 32'hE);
         chk($sformatf("rel_busy_k%0d", k),  32'(busy_o),  (k <= 10) ? 32'd1 : 32'd0);
         chk($sformatf("rel_done_k%0d", k),  32'(done_o),  (k == 11) ? 32'd1 : 32'd0);
         chk($sformatf("rel_ready_k%0d", k), 32'(ready_o), (k == 12) ? 32'd1 : 32'd0);
         if (k < 12) tick();
      end

      // ASSERT_ALL from all-released: all 1 from T+1, busy T+1..T+4, done T+5
      v_i = 1'b1; cmd_i = e_pod_reset_assert_all;
      tick();
      v_i = 1'b0; cmd_i = e_pod_reset_nop;
      for (int k = 1; k <= 6; k++) begin
         chk($sformatf("asr_pod_k%0d", k),   32'(pod_reset_o), 32'h0000_000F);
         chk($sformatf("asr_busy_k%0d", k),  32'(busy_o),  (k <= 4) ? 32'd1 : 32'd0);
         chk($sformatf("asr_done_k%0d", k),  32'(done_o),  (k == 5) ? 32'd1 : 32'd0);
         chk($sformatf("asr_ready_k%0d", k), 32'(ready_o), (k == 6) ? 32'd1 : 32'd0);
         if (k < 6) tick();
      end

      // Back-pressure: NOP held on v_i during RELEASE_ALL is taken only at T+12
      v_i = 1'b1; cmd_i = e_pod_reset_release_all;
      tick();
      cmd_i = e_pod_reset_nop;
      for (int k = 1; k <= 13; k++) begin
         chk($sformatf("bp_ready_k%0d", k), 32'(ready_o), (k == 12) ? 32'd1 : 32'd0);
         chk($sformatf("bp_done_k%0d", k),  32'(done_o),  (k == 11 || k == 13) ? 32'd1 : 32'd0);
         if (k < 13) tick();
      end
      chk("bp_pod", 32'(pod_reset_o), 32'h0000_0000);
      v_i = 1'b0;
      tick();
      chk("bp_ready_after", 32'(ready_o), 32'd1);
      chk("bp_done_after",  32'(done_o),  32'd0);

      // PULSE_ONE x=1,y=0: bit1 high T+1..T+4, low with done at T+5
      v_i = 1'b1; cmd_i = e_pod_reset_pulse_one; pod_x_i = 1'b1; pod_y_i = 1'b0;
      tick();
      v_i = 1'b0; cmd_i = e_pod_reset_nop;
      for (int k = 1; k <= 6; k++) begin
         chk($sformatf("p10_pod_k%0d", k),   32'(pod_reset_o), (k <= 4) ? 32'h2 : 32'h0);
         chk($sformatf("p10_done_k%0d", k),  32'(done_o),  (k == 5) ? 32'd1 : 32'd0);
         chk($sformatf("p10_ready_k%0d", k), 32'(ready_o), (k == 6) ? 32'd1 : 32'd0);
         if (k < 6) tick();
      end

      // PULSE_ONE x=0,y=1 targets linear index 2
      v_i = 1'b1; cmd_i = e_pod_reset_pulse_one; pod_x_i = 1'b0; pod_y_i = 1'b1;
      tick();
      v_i = 1'b0; cmd_i = e_pod_reset_nop;
      chk("p01_pod_k1",  32'(pod_reset_o), 32'h0000_0004);
      chk("p01_busy_k1", 32'(busy_o), 32'd1);
      repeat (4) tick();
      chk("p01_pod_k5",  32'(pod_reset_o), 32'h0000_0000);
      chk("p01_done_k5", 32'(done_o), 32'd1);
      tick();

      // NOP: done at T+1, ready at T+2, no bit changes
      v_i = 1'b1; cmd_i = e_pod_reset_nop;
      tick();
      v_i = 1'b0;
      chk("nop_done_k1",  32'(done_o),  32'd1);
      chk("nop_busy_k1",  32'(busy_o),  32'd0);
      chk("nop_pod_k1",   32'(pod_reset_o), 32'h0000_0000);
      tick();
      chk("nop_ready_k2", 32'(ready_o), 32'd1);
      chk("nop_done_k2",  32'(done_o),  32'd0);

      // Out-of-range PULSE_ONE (row 3 of 3) on the 2x3 instance
      v2_i = 1'b1; cmd2_i = e_pod_reset_pulse_one; pod_x2_i = 1'b0; pod_y2_i = 2'd3;
      tick();
      v2_i = 1'b0; cmd2_i = e_pod_reset_nop;
      chk("oor_done_k1",  32'(done2_o), 32'd1);
      chk("oor_busy_k1",  32'(busy2_o), 32'd0);
      chk("oor_pod_k1",   32'(pod_reset2_o), 32'h0000_003F);
      tick();
      chk("oor_ready_k2", 32'(ready2_o), 32'd1);
      chk("oor_pod_k2",   32'(pod_reset2_o), 32'h0000_003F);

      // Async reset in the middle of a RELEASE_ALL
      v_i = 1'b1; cmd_i = e_pod_reset_assert_all;
      tick();
      v_i = 1'b0; cmd_i = e_pod_reset_nop;
      repeat (5) tick();
      v_i = 1'b1; cmd_i = e_pod_reset_release_all;
      tick();
      v_i = 1'b0; cmd_i = e_pod_reset_nop;
      repeat (4) tick();
      chk("arst_pre_pod", 32'(pod_reset_o), 32'h0000_000C);
      #2 reset_n_i = 1'b0;
      #1;
      chk("arst_pod",   32'(pod_reset_o), 32'h0000_000F);
      chk("arst_ready", 32'(ready_o), 32'd1);
      chk("arst_busy",  32'(busy_o),  32'd0);
      chk("arst_done",  32'(done_o),  32'd0);
      @(negedge clk_i) reset_n_i = 1'b1;
      tick();
      repeat (5) tick();
      chk("arst_after_pod",   32'(pod_reset_o), 32'h0000_000F);
      chk("arst_after_ready", 32'(ready_o), 32'd1);
      chk("arst_after_busy",  32'(busy_o),  32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
